// File: rtl/lossless_decoder_if.sv
// Bus between lossless_decoder and its environment: the Start/Finish
// handshake with the top-level FSM plus the SRAM port it borrows through the
// SRAM mux while the top level sits in S_M3.
//
// Handshake: Start is a one-cycle pulse. It is only honoured while the
// decoder is idle. Finish is a one-cycle pulse raised after the last
// coefficient of the last block has been written. SRAM reads return data two
// cycles after the address is presented. A write happens in the cycle where
// SRAM_we_n is low, with the address and data valid in that same cycle.
// dbg_state mirrors the decoder FSM state.
interface lossless_decoder_if;
   logic        Start;
   logic        Finish;
   logic [15:0] SRAM_read_data;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;
   logic [3:0]  dbg_state;

   modport master (
      input  Start, SRAM_read_data,
      output Finish, SRAM_address, SRAM_write_data, SRAM_we_n, dbg_state
   );

   modport slave (
      output Start, SRAM_read_data,
      input  Finish, SRAM_address, SRAM_write_data, SRAM_we_n, dbg_state
   );
endinterface

// File: rtl/lossless_decoder.sv
// lossless_decoder: milestone-3 stage ahead of the IDCT controller.
// Reads the variable-length-coded bitstream from SRAM, expands it into 8x8
// blocks in zigzag order, and writes every coefficient (zeros included) as a
// 16-bit signed word into the coefficient segment.
// Optional feature macro: LD_DEQUANT_EN. When it is defined, each
// coefficient is shifted left by the Q0/Q1 step for its (row+col).
// Otherwise the raw sign-extended value is written, which matches the
// software decoder's pre-dequant dump.
module lossless_decoder #(
   parameter logic [17:0] BITSTREAM_BASE = 18'd76800,
   parameter logic [17:0] COEFF_BASE     = 18'd0,
   parameter logic [11:0] NUM_BLOCKS     = 12'd2400
) (
   input  logic               CLOCK_50_I,
   input  logic               resetn,
   lossless_decoder_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR_FETCH, S_HDR_WAIT1, S_HDR_WAIT2,
      S_FETCH, S_WAIT1, S_WAIT2, S_DECODE, S_WRITE, S_DONE
   } state_t;

   // Zigzag position k -> row*8+col inside the block.
   localparam logic [5:0] ZZ [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   localparam logic [11:0] LAST_BLK = 12'(NUM_BLOCKS - 12'd1);

   state_t      r_state, w_next;
   logic [31:0] r_buf;     // valid bits left-aligned, consumed from bit 31
   logic [5:0]  r_cnt;     // number of valid bits in r_buf
   logic [17:0] r_ptr;     // next bitstream word to fetch
   logic        r_qsel;
   logic [11:0] r_blk;
   logic [5:0]  r_k;       // zigzag index within the current block
   logic [6:0]  r_rem;     // writes still owed by the current code
   logic [15:0] r_val;     // sign-extended value of the current code

   logic [3:0]  w_len;
   logic [15:0] w_dval;
   logic [6:0]  w_drem;
   logic [6:0]  w_run;
   logic [6:0]  w_left;
   logic [5:0]  w_zz;
   logic [3:0]  w_rc;
   logic [3:0]  w_shift;
   logic        w_last_k;
   logic        w_last_blk;
   logic        w_code_done;
   logic [17:0] w_addr;
   logic [15:0] w_wdata;
   logic        w_we_n;
   logic        w_finish;

   assign w_left      = 7'd64 - {1'b0, r_k};
   assign w_zz        = ZZ[r_k];
   assign w_rc        = {1'b0, w_zz[5:3]} + {1'b0, w_zz[2:0]};
   assign w_last_k    = (r_k == 6'd63);
   assign w_last_blk  = (r_blk == LAST_BLK);
   assign w_code_done = w_last_k || (r_rem == 7'd1);

`ifdef LD_DEQUANT_EN
   // Left-shift step for a coefficient at diagonal row+col.
   function automatic logic [3:0] f_shift(input logic q, input logic [3:0] rc);
      logic [3:0] s;
      if (!q) begin
         if (rc == 4'd0)       s = 4'd3;
         else if (rc == 4'd1)  s = 4'd2;
         else if (rc <= 4'd3)  s = 4'd3;
         else if (rc <= 4'd5)  s = 4'd4;
         else if (rc <= 4'd7)  s = 4'd5;
         else                  s = 4'd6;
      end else begin
         if (rc == 4'd0)       s = 4'd3;
         else if (rc <= 4'd3)  s = 4'd1;
         else if (rc <= 4'd5)  s = 4'd2;
         else if (rc <= 4'd7)  s = 4'd3;
         else if (rc <= 4'd11) s = 4'd4;
         else                  s = 4'd5;
      end
      return s;
   endfunction

   assign w_shift = f_shift(r_qsel, w_rc);
`else
   logic w_unused_nodeq;
   assign w_unused_nodeq = ^{r_qsel, w_rc};
   assign w_shift = 4'd0;
`endif

   // Parse the code at the top of the bit buffer: length, value, write count.
   always_comb begin
      w_len  = 4'd3;
      w_dval = 16'd0;
      w_run  = 7'd8;
      w_drem = w_left;
      case (r_buf[31:30])
         2'b00: begin
            w_len  = 4'd5;
            w_dval = {{13{r_buf[29]}}, r_buf[29:27]};
            w_drem = 7'd1;
         end
         2'b01: begin
            w_len  = 4'd8;
            w_dval = {{10{r_buf[29]}}, r_buf[29:24]};
            w_drem = 7'd1;
         end
         2'b10: begin
            w_len  = 4'd11;
            w_dval = {{7{r_buf[29]}}, r_buf[29:21]};
            w_drem = 7'd1;
         end
         default: begin
            if (!r_buf[29]) begin
               w_len = 4'd6;
               if (r_buf[28:26] != 3'd0) w_run = {4'd0, r_buf[28:26]};
               // A run past the end of the block is cut at k=63.
               w_drem = (w_run > w_left) ? w_left : w_run;
            end
         end
      endcase
   end

   // State register.
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (bus.Start) w_next = S_HDR_FETCH;
         S_HDR_FETCH: w_next = S_HDR_WAIT1;
         S_HDR_WAIT1: w_next = S_HDR_WAIT2;
         S_HDR_WAIT2: w_next = S_FETCH;
         S_FETCH:     w_next = S_WAIT1;
         S_WAIT1:     w_next = S_WAIT2;
         S_WAIT2:     w_next = S_DECODE;
         S_DECODE:    w_next = S_WRITE;
         S_WRITE: begin
            if (w_last_k && w_last_blk) w_next = S_DONE;
            else if (w_code_done)       w_next = (r_cnt < 6'd16) ? S_FETCH : S_DECODE;
            else                        w_next = S_WRITE;
         end
         S_DONE:      w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   // Bit buffer, pointers and block/position counters.
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         r_buf  <= 32'd0;
         r_cnt  <= 6'd0;
         r_ptr  <= 18'd0;
         r_qsel <= 1'b0;
         r_blk  <= 12'd0;
         r_k    <= 6'd0;
         r_rem  <= 7'd0;
         r_val  <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.Start) begin
                  r_buf <= 32'd0;
                  r_cnt <= 6'd0;
                  r_ptr <= BITSTREAM_BASE + 18'd1;
                  r_blk <= 12'd0;
                  r_k   <= 6'd0;
                  r_rem <= 7'd0;
                  r_val <= 16'd0;
               end
            end
            S_HDR_WAIT2: r_qsel <= bus.SRAM_read_data[15];
            S_WAIT2: begin
               r_buf <= r_buf | ({bus.SRAM_read_data, 16'd0} >> r_cnt);
               r_cnt <= r_cnt + 6'd16;
               r_ptr <= r_ptr + 18'd1;
            end
            S_DECODE: begin
               r_buf <= r_buf << w_len;
               r_cnt <= r_cnt - {2'd0, w_len};
               r_val <= w_dval;
               r_rem <= w_drem;
            end
            S_WRITE: begin
               r_rem <= r_rem - 7'd1;
               if (w_last_k) begin
                  r_k   <= 6'd0;
                  r_blk <= r_blk + 12'd1;
               end else begin
                  r_k <= r_k + 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // SRAM and handshake outputs, decoded from the current state.
   always_comb begin
      w_addr   = 18'd0;
      w_wdata  = 16'd0;
      w_we_n   = 1'b1;
      w_finish = 1'b0;
      case (r_state)
         S_HDR_FETCH: w_addr = BITSTREAM_BASE;
         S_FETCH:     w_addr = r_ptr;
         S_WRITE: begin
            w_addr  = COEFF_BASE + {r_blk, 6'd0} + {12'd0, w_zz};
            w_wdata = r_val << w_shift;
            w_we_n  = 1'b0;
         end
         S_DONE:      w_finish = 1'b1;
         default: ;
      endcase
   end

   assign bus.SRAM_address    = w_addr;
   assign bus.SRAM_write_data = w_wdata;
   assign bus.SRAM_we_n       = w_we_n;
   assign bus.Finish          = w_finish;
   assign bus.dbg_state       = r_state;

endmodule

// File: tb/tb_lossless_decoder.sv
// Bench for lossless_decoder built with two blocks per run. Directed
// bitstreams with hand-computed coefficient images. The SRAM model answers
// reads with two cycles of latency. A monitor checks every write, in order,
// against the expected (address, data) queue.
module tb_lossless_decoder;
  localparam logic [17:0] BASE = 18'd76800;

  logic CLOCK_50_I = 1'b0;
  logic resetn     = 1'b0;

  lossless_decoder_if bus();

  lossless_decoder #(
    .BITSTREAM_BASE(BASE),
    .COEFF_BASE(18'd0),
    .NUM_BLOCKS(12'd2)
  ) dut (
    .CLOCK_50_I(CLOCK_50_I),
    .resetn(resetn),
    .bus(bus)
  );

  // clock / reset
  always #10 CLOCK_50_I = ~CLOCK_50_I;

  int zz [0:63] = '{
    0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic [15:0] bs [0:15];
  logic [15:0] img [0:127];
  logic [15:0] rd_pipe;
  logic [33:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int fin_cnt  = 0;

  // SRAM model: bitstream window at BASE, two-cycle read latency
  always @(posedge CLOCK_50_I) begin
    int idx;
    idx = int'(bus.SRAM_address) - int'(BASE);
    rd_pipe <= (idx >= 0 && idx < 16) ? bs[idx] : 16'h0000;
    bus.SRAM_read_data <= rd_pipe;
  end

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge CLOCK_50_I) begin
    if (resetn) begin
      if (bus.Finish === 1'b1) fin_cnt++;
      if (bus.SRAM_we_n === 1'b0) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {bus.SRAM_address, bus.SRAM_write_data}, 34'h0);
          if (bus.SRAM_address == 18'd0 && bus.SRAM_write_data == 16'd0) begin
            n_fail++;
            $display("FAIL unexpected_write: got write with empty queue required none");
          end
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          check("write", {bus.SRAM_address, bus.SRAM_write_data}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic clear_all();
    for (int i = 0; i < 16; i++) bs[i] = 16'h0000;
    for (int i = 0; i < 128; i++) img[i] = 16'h0000;
  endtask

  task automatic set_coef(input int a, input logic [15:0] deq, input logic [15:0] raw);
`ifdef LD_DEQUANT_EN
    img[a] = deq;
`else
    img[a] = raw;
`endif
  endtask

  task automatic build_queue();
    exp_q.delete();
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 64; k++) begin
        int a;
        a = b * 64 + zz[k];
        exp_q.push_back({18'(a), img[a]});
      end
    wr_cnt  = 0;
    fin_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge CLOCK_50_I);
    bus.Start = 1'b1;
    @(negedge CLOCK_50_I);
    bus.Start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_finish"}, {33'd0, bus.Finish}, 34'd0);
    check({tag, "_we_n"}, {33'd0, bus.SRAM_we_n}, 34'd1);
    check({tag, "_addr"}, {16'd0, bus.SRAM_address}, 34'd0);
    check({tag, "_wdata"}, {18'd0, bus.SRAM_write_data}, 34'd0);
    check({tag, "_state"}, {30'd0, bus.dbg_state}, 34'd0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (fin_cnt == 0 && n < 3000) begin
      @(negedge CLOCK_50_I);
      n++;
    end
    repeat (5) @(negedge CLOCK_50_I);
    check({name, "_finish_count"}, 34'(fin_cnt), 34'd1);
    check({name, "_write_count"}, 34'(wr_cnt), 34'd128);
    check({name, "_queue_left"}, 34'(exp_q.size()), 34'd0);
    check({name, "_idle"}, {30'd0, bus.dbg_state}, 34'd0);
  endtask

  task automatic load_t1();
    clear_all();
    bs[0] = 16'h0000; bs[1] = 16'h1FF0;          // "00 011","111" | "111"
    set_coef(0, 16'h0018, 16'h0003);
  endtask

  initial begin
    bus.Start = 1'b0;
    repeat (3) @(negedge CLOCK_50_I);
    check_reset_outputs("reset");
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50_I);

    // T1: single small positive coefficient, then end-of-block twice
    load_t1();
    build_queue();
    pulse_start();
    wait_done("t1");

    // T2: 6-bit code, most negative value
    clear_all();
    bs[0] = 16'h0000; bs[1] = 16'h60FC;          // "01 100000","111" | "111"
    set_coef(0, 16'hFF00, 16'hFFE0);
    build_queue();
    pulse_start();
    wait_done("t2");

    // T3: Q1 table, explicit zero then 1 at k=1
    clear_all();
    bs[0] = 16'h8000; bs[1] = 16'h007F;          // "00 000","00 001","111" | "111"
    set_coef(1, 16'h0002, 16'h0001);
    build_queue();
    pulse_start();
    wait_done("t3");

    // T4: eight runs of 8 fill block 0; Start pulses mid-run are ignored
    clear_all();
    bs[0] = 16'h0000; bs[1] = 16'hC30C; bs[2] = 16'h30C3; bs[3] = 16'h0C30;
    bs[4] = 16'h0F00;                            // then "00 001","111"
    set_coef(64, 16'h0008, 16'h0001);
    build_queue();
    pulse_start();
    repeat (30) @(negedge CLOCK_50_I);
    pulse_start();
    repeat (40) @(negedge CLOCK_50_I);
    pulse_start();
    wait_done("t4");

    // T5: Q1, 9-bit -256, short run, 6-bit 31 at k=4; block 1 ends with clipped run
    clear_all();
    bs[0] = 16'h8000; bs[1] = 16'hA019; bs[2] = 16'hAFF3; bs[3] = 16'hE186;
    bs[4] = 16'h1861; bs[5] = 16'h8618;
    set_coef(0, 16'hF800, 16'hFF00);
    set_coef(9, 16'h003E, 16'h001F);
    set_coef(64, 16'hFFF8, 16'hFFFF);
    build_queue();
    pulse_start();
    wait_done("t5");

    // T6: "111" at k=0, then block 1 filled by runs with a coefficient at k=63
    clear_all();
    bs[0] = 16'h0000; bs[1] = 16'hF861; bs[2] = 16'h8618; bs[3] = 16'h6186;
    bs[4] = 16'hE300;
    set_coef(127, 16'h00C0, 16'h0003);
    build_queue();
    pulse_start();
    wait_done("t6");

    // T7: reset during block 0 writes, then a clean rerun of T1
    load_t1();
    build_queue();
    pulse_start();
    begin
      int n;
      n = 0;
      while (wr_cnt < 10 && n < 1000) begin
        @(negedge CLOCK_50_I);
        n++;
      end
      check("t7_writes_before_reset", 34'(wr_cnt >= 10), 34'd1);
    end
    resetn = 1'b0;
    @(posedge CLOCK_50_I);
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    @(negedge CLOCK_50_I);
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50_I);
    build_queue();
    pulse_start();
    wait_done("t7_rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
